sqrt_ctrl_fsm: RTL and testbench



---
 rtl/sqrt_ctrl_fsm_if.sv | 33 +++
 rtl/sqrt_ctrl_fsm.sv | 138 +++++++++++++
 tb/tb_sqrt_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_ctrl_fsm_if.sv
// Control bundle between the magnitude-approximation sequencer and its datapath.
// The slave side is the sequencer itself; the master side is the requester/datapath.
interface sqrt_ctrl_fsm_if;
  logic       start;
  logic       ready;
  logic       done;
  logic       R1_e, R2_e, R3_e, R4_e, R5_e;
  logic       In1_tri, In2_tri;
  logic       AU1_tri, AU1_tri1;
  logic       R1_tri, R2_tri;
  logic       shift3_tri, AU2_tri;
  logic       R4_tri, R5_tri;
  logic [1:0] AU1_op;
  logic [1:0] AU2_op;

  modport master (
    output start,
    input  ready, done,
    input  R1_e, R2_e, R3_e, R4_e, R5_e,
    input  In1_tri, In2_tri, AU1_tri, AU1_tri1,
    input  R1_tri, R2_tri, shift3_tri, AU2_tri, R4_tri, R5_tri,
    input  AU1_op, AU2_op
  );

  modport slave (
    input  start,
    output ready, done,
    output R1_e, R2_e, R3_e, R4_e, R5_e,
    output In1_tri, In2_tri, AU1_tri, AU1_tri1,
    output R1_tri, R2_tri, shift3_tri, AU2_tri, R4_tri, R5_tri,
    output AU1_op, AU2_op
  );
endinterface

// File: rtl/sqrt_ctrl_fsm.sv
// Moore sequencer for sqrt(a^2+b^2) ~ max(x - x/8 + y/2, x): walks a fixed
// 8-step schedule, then holds done for DONE_CYCLES cycles.
module sqrt_ctrl_fsm #(
  parameter int DONE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clear,
  sqrt_ctrl_fsm_if.slave   ctl
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_ABS1 = 4'd2,
    S_ABS2 = 4'd3,
    S_MAXV = 4'd4,
    S_MINV = 4'd5,
    S_SUB  = 4'd6,
    S_ADD  = 4'd7,
    S_MAXF = 4'd8,
    S_DONE = 4'd9
  } state_t;

  localparam logic [3:0] LAST_DONE = 4'(DONE_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      S_IDLE: if (ctl.start) state_next = S_LOAD;
      S_LOAD: state_next = S_ABS1;
      S_ABS1: state_next = S_ABS2;
      S_ABS2: state_next = S_MAXV;
      S_MAXV: state_next = S_MINV;
      S_MINV: state_next = S_SUB;
      S_SUB:  state_next = S_ADD;
      S_ADD:  state_next = S_MAXF;
      S_MAXF: state_next = S_DONE;
      S_DONE: begin
        // start is only honoured on the final done cycle, giving back-to-back runs
        if (cnt_reg == LAST_DONE) begin
          state_next = ctl.start ? S_LOAD : S_IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ctl.ready      = 1'b0;
    ctl.done       = 1'b0;
    ctl.R1_e       = 1'b0;
    ctl.R2_e       = 1'b0;
    ctl.R3_e       = 1'b0;
    ctl.R4_e       = 1'b0;
    ctl.R5_e       = 1'b0;
    ctl.In1_tri    = 1'b0;
    ctl.In2_tri    = 1'b0;
    ctl.AU1_tri    = 1'b0;
    ctl.AU1_tri1   = 1'b0;
    ctl.R1_tri     = 1'b0;
    ctl.R2_tri     = 1'b0;
    ctl.shift3_tri = 1'b0;
    ctl.AU2_tri    = 1'b0;
    ctl.R4_tri     = 1'b0;
    ctl.R5_tri     = 1'b0;
    ctl.AU1_op     = 2'b00;
    ctl.AU2_op     = 2'b00;
    case (state_reg)
      S_IDLE: ctl.ready = 1'b1;
      S_LOAD: begin
        ctl.In1_tri = 1'b1;
        ctl.In2_tri = 1'b1;
        ctl.R1_e    = 1'b1;
        ctl.R2_e    = 1'b1;
      end
      S_ABS1: begin
        ctl.R2_tri   = 1'b1;
        ctl.AU1_tri1 = 1'b1;
        ctl.R2_e     = 1'b1;
      end
      S_ABS2: begin
        ctl.R1_tri  = 1'b1;
        ctl.AU1_tri = 1'b1;
        ctl.R1_e    = 1'b1;
      end
      S_MAXV: begin
        // x goes to R4 and x>>3 to R3 in the same cycle
        ctl.R2_tri     = 1'b1;
        ctl.AU1_op     = 2'b01;
        ctl.R4_e       = 1'b1;
        ctl.shift3_tri = 1'b1;
        ctl.R3_e       = 1'b1;
      end
      S_MINV: begin
        ctl.R2_tri = 1'b1;
        ctl.AU1_op = 2'b10;
        ctl.R5_e   = 1'b1;
      end
      S_SUB: begin
        ctl.R4_tri  = 1'b1;
        ctl.AU2_op  = 2'b10;
        ctl.AU2_tri = 1'b1;
        ctl.R3_e    = 1'b1;
      end
      S_ADD: begin
        ctl.R5_tri  = 1'b1;
        ctl.AU2_op  = 2'b00;
        ctl.AU2_tri = 1'b1;
        ctl.R3_e    = 1'b1;
      end
      S_MAXF: begin
        ctl.R4_tri  = 1'b1;
        ctl.AU2_op  = 2'b01;
        ctl.AU2_tri = 1'b1;
        ctl.R3_e    = 1'b1;
      end
      S_DONE: ctl.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sqrt_ctrl_fsm.sv
// Directed bench: per-state control vectors, a datapath model for end-to-end
// results, back-to-back timing, mid-run clear and dropped start.
module tb_sqrt_ctrl_fsm;
  logic clk;
  logic clear;

  sqrt_ctrl_fsm_if if1 ();
  sqrt_ctrl_fsm_if if3 ();

  sqrt_ctrl_fsm #(.DONE_CYCLES(1)) dut1 (.clk(clk), .clear(clear), .ctl(if1.slave));
  sqrt_ctrl_fsm #(.DONE_CYCLES(3)) dut3 (.clk(clk), .clear(clear), .ctl(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {ready, R1..R5_e, In1, In2, AU1, AU1_1, R1t, R2t, sh3, AU2, R4t, R5t, AU1_op, AU2_op, done}
  logic [20:0] v1, v3;
  assign v1 = {if1.ready, if1.R1_e, if1.R2_e, if1.R3_e, if1.R4_e, if1.R5_e,
               if1.In1_tri, if1.In2_tri, if1.AU1_tri, if1.AU1_tri1, if1.R1_tri, if1.R2_tri,
               if1.shift3_tri, if1.AU2_tri, if1.R4_tri, if1.R5_tri, if1.AU1_op, if1.AU2_op, if1.done};
  assign v3 = {if3.ready, if3.R1_e, if3.R2_e, if3.R3_e, if3.R4_e, if3.R5_e,
               if3.In1_tri, if3.In2_tri, if3.AU1_tri, if3.AU1_tri1, if3.R1_tri, if3.R2_tri,
               if3.shift3_tri, if3.AU2_tri, if3.R4_tri, if3.R5_tri, if3.AU1_op, if3.AU2_op, if3.done};

  localparam logic [20:0] B_RDY = 21'(1) << 20, B_R1E = 21'(1) << 19, B_R2E = 21'(1) << 18,
                          B_R3E = 21'(1) << 17, B_R4E = 21'(1) << 16, B_R5E = 21'(1) << 15,
                          B_IN1 = 21'(1) << 14, B_IN2 = 21'(1) << 13, B_A1T = 21'(1) << 12,
                          B_A1T1 = 21'(1) << 11, B_R1T = 21'(1) << 10, B_R2T = 21'(1) << 9,
                          B_SH3 = 21'(1) << 8, B_A2T = 21'(1) << 7, B_R4T = 21'(1) << 6,
                          B_R5T = 21'(1) << 5, A1_MAX = 21'(1) << 3, A1_MIN = 21'(2) << 3,
                          A2_MAX = 21'(1) << 1, A2_SUB = 21'(2) << 1, B_DONE = 21'(1);

  localparam logic [20:0] E_IDLE = B_RDY;
  localparam logic [20:0] E_LOAD = B_IN1 | B_IN2 | B_R1E | B_R2E;
  localparam logic [20:0] E_ABS1 = B_R2T | B_A1T1 | B_R2E;
  localparam logic [20:0] E_ABS2 = B_R1T | B_A1T | B_R1E;
  localparam logic [20:0] E_MAXV = B_R2T | A1_MAX | B_R4E | B_SH3 | B_R3E;
  localparam logic [20:0] E_MINV = B_R2T | A1_MIN | B_R5E;
  localparam logic [20:0] E_SUB  = B_R4T | A2_SUB | B_A2T | B_R3E;
  localparam logic [20:0] E_ADD  = B_R5T | B_A2T | B_R3E;
  localparam logic [20:0] E_MAXF = B_R4T | A2_MAX | B_A2T | B_R3E;
  localparam logic [20:0] E_DONE = B_DONE;

  typedef struct {
    logic        start;
    logic [20:0] exp;
  } vec_t;
  vec_t tbl [11];

  // Datapath model driven by dut1's controls (5-bit two's complement)
  logic [4:0] in1, in2;
  logic [4:0] r1, r2, r3, r4, r5;
  logic [4:0] au1_b, au1_y, au2_a, au2_y;

  always_comb begin
    au1_b = if1.R1_tri ? r1 : (if1.R2_tri ? r2 : 5'd0);
    case (if1.AU1_op)
      2'b00:   au1_y = au1_b[4] ? 5'(-au1_b) : au1_b;
      2'b01:   au1_y = (r1 > au1_b) ? r1 : au1_b;
      2'b10:   au1_y = (r1 < au1_b) ? r1 : au1_b;
      default: au1_y = r1 - au1_b;
    endcase
    au2_a = if1.R4_tri ? r4 : (if1.R5_tri ? r5 : 5'd0);
    case (if1.AU2_op)
      2'b00:   au2_y = au2_a + r3;
      2'b01:   au2_y = (au2_a > r3) ? au2_a : r3;
      2'b10:   au2_y = au2_a - r3;
      default: au2_y = au2_a;
    endcase
  end

  always @(posedge clk) begin
    if (if1.R1_e) r1 <= if1.In2_tri ? in2 : (if1.AU1_tri ? au1_y : 5'd0);
    if (if1.R2_e) r2 <= if1.In1_tri ? in1 : (if1.AU1_tri1 ? au1_y : 5'd0);
    if (if1.R3_e) r3 <= if1.shift3_tri ? (au1_y >> 3) : (if1.AU2_tri ? au2_y : 5'd0);
    if (if1.R4_e) r4 <= au1_y;
    if (if1.R5_e) r5 <= au1_y >> 1;
  end

  function automatic logic bad(logic [20:0] v);
    return (v[13] & v[12]) | (v[14] & v[11]) | (v[8] & v[7]) | (v[6] & v[5]) |
           (v[10] & v[9]) | (v[4:3] == 2'b11) | (v[2:1] == 2'b11);
  endfunction

  // Bus-contention and opcode invariant on every cycle for both instances
  always @(negedge clk) begin
    checks++;
    if (bad(v1) === 1'b1 || bad(v3) === 1'b1) begin
      errors++;
      $display("FAIL invariant at %0t: dut1=%h dut3=%h required no contention/opcode 11", $time, v1, v3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [20:0] act, logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic run_dp(logic [4:0] a, logic [4:0] b, logic [4:0] exp_res);
    bit seen;
    in1 = a;
    in2 = b;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("dp %0d,%0d done/result", a, b), {15'd0, seen, r3}, {15'd0, 1'b1, exp_res});
    tick();
    chk("dp back to idle", v1, E_IDLE);
  endtask

  initial begin
    tbl[0]  = '{1'b1, E_LOAD};
    tbl[1]  = '{1'b0, E_ABS1};
    tbl[2]  = '{1'b0, E_ABS2};
    tbl[3]  = '{1'b0, E_MAXV};
    tbl[4]  = '{1'b0, E_MINV};
    tbl[5]  = '{1'b0, E_SUB};
    tbl[6]  = '{1'b0, E_ADD};
    tbl[7]  = '{1'b0, E_MAXF};
    tbl[8]  = '{1'b0, E_DONE};
    tbl[9]  = '{1'b0, E_IDLE};
    tbl[10] = '{1'b0, E_IDLE};
    in1 = '0;
    in2 = '0;

    // Reset held with start high
    clear = 1'b1;
    if1.start = 1'b1;
    if3.start = 1'b1;
    tick();
    chk("reset1 dut1", v1, E_IDLE);
    chk("reset1 dut3", v3, E_IDLE);
    tick();
    chk("reset2 dut1", v1, E_IDLE);
    chk("reset2 dut3", v3, E_IDLE);
    clear = 1'b0;
    if1.start = 1'b0;
    if3.start = 1'b0;
    tick();
    chk("idle after clear", v1, E_IDLE);

    // Single run, per-state control vectors
    for (int i = 0; i < 11; i++) begin
      if1.start = tbl[i].start;
      tick();
      chk($sformatf("vec %0d", i), v1, tbl[i].exp);
    end

    // End-to-end results through the datapath model
    run_dp(5'b00011, 5'b11100, 5'd5);
    run_dp(5'd0, 5'd0, 5'd0);
    run_dp(5'd7, 5'd1, 5'd7);

    // Back-to-back with DONE_CYCLES=3: period 11, done for 3, no idle gap
    if3.start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      int ph;
      tick();
      ph = (c - 1) % 11;
      chk($sformatf("b2b cycle %0d {ready,load,done}", c),
          {18'd0, if3.ready, if3.In1_tri, if3.done},
          {18'd0, 1'b0, ph == 0, ph >= 8});
    end
    if3.start = 1'b0;
    tick();
    chk("b2b release idle", v3, E_IDLE);

    // Clear during SUB
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("midrun in SUB", v1, E_SUB);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("midrun clear idle", v1, E_IDLE);

    // Start pulse in ADD is dropped
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ignored: in ADD", v1, E_ADD);
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    chk("ignored: MAXF", v1, E_MAXF);
    tick();
    chk("ignored: DONE", v1, E_DONE);
    tick();
    chk("ignored: back to IDLE", v1, E_IDLE);
    tick();
    chk("ignored: stays IDLE", v1, E_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
